task_create_ack_buffer: RTL
===========================

Name: task_create_ack_buffer

Overview:
- Elastic FIFO stage directly downstream of the two-to-one task-create-ack switch.
- Absorbs 64-bit task-create acknowledgement messages and their tdest from the switch master port.
- Re-issues them in order to the consuming accelerator-side interconnect.
- Decouples ack producers from back-pressure, and reports occupancy for debug and flow-control monitoring.

Parameters:
- DEST_WIDTH, 8, width of the tdest field carried with each ack.
- DEPTH, 16, number of entries; power of two, minimum 2.
- DATA_WIDTH, 64, local constant; ack payload width, not overridable.
- CNT_WIDTH, $clog2(DEPTH)+1, local constant; occupancy counter width.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- S_AXIS_tvalid  input  1  ack valid from the switch.
- S_AXIS_tready  output  1  buffer can accept an ack.
- S_AXIS_tdata  input  DATA_WIDTH  ack payload.
- S_AXIS_tdest  input  DEST_WIDTH  ack destination.
- M_AXIS_tvalid  output  1  ack valid to the consumer.
- M_AXIS_tready  input  1  consumer accepts the ack.
- M_AXIS_tdata  output  DATA_WIDTH  ack payload, registered.
- M_AXIS_tdest  output  DEST_WIDTH  ack destination, registered.
- occupancy  output  CNT_WIDTH  number of acks held, including the output register.

Behaviour:
- Reset (asynchronous, active-high): while rst=1 and on release:
  - S_AXIS_tready=0, M_AXIS_tvalid=0, M_AXIS_tdata=0, M_AXIS_tdest=0, occupancy=0.
  - Read and write pointers cleared.
  - S_AXIS_tready rises on the first clk edge after rst deasserts.
  - Reset mid-transfer discards all stored acks; no partial output.
- Storage: RAM of DEPTH-1 entries plus one output register, DEPTH total. Pointers are $clog2(DEPTH-1)-bit binary and wrap modulo DEPTH-1.
- Push: S_AXIS_tvalid & S_AXIS_tready.
- Pop: M_AXIS_tvalid & M_AXIS_tready.
- Handshakes are AXI-Stream compliant:
  - M_AXIS_tvalid never deasserts without a pop.
  - M_AXIS_tdata/tdest stay stable while tvalid=1 and tready=0.
- S_AXIS_tready = registered (occupancy < DEPTH) after the update. No combinational path from M_AXIS_tready to S_AXIS_tready.
- Latency: an ack pushed into an empty buffer appears on M_AXIS the next cycle (1-cycle fall-through via the output register). No same-cycle bypass.
- Output register load rules:
  - Loads when it is empty or being popped, and the RAM holds data or a push is occurring.
  - RAM data has priority over the incoming ack to preserve order.
  - The incoming ack goes straight to the output register only when the RAM is empty.
- Occupancy: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Boundary conditions:
  - Full (occupancy=DEPTH): S_AXIS_tready=0. Any push attempt is ignored and S_AXIS_tvalid is held by the source.
  - Simultaneous push and pop while full cannot occur, because ready is low.
  - Simultaneous push and pop at occupancy=DEPTH-1: both accepted; occupancy stays DEPTH-1 and tready stays 1.
  - Empty with no push: M_AXIS_tvalid=0 and tdata holds its last value.
- Ordering: strict FIFO; tdata and tdest always travel together.

Optional Feature:
- Macro: TASK_CREATE_ACK_BUFFER_STATS_EN.
- When defined:
  - Adds outputs ack_count (32 bits) and max_occupancy (CNT_WIDTH bits).
  - ack_count increments on every pop and wraps 0xFFFFFFFF to 0.
  - max_occupancy is a high-water mark of occupancy.
  - Both are cleared by rst.
- When undefined: these ports and registers do not exist, and core behaviour is identical.

Test Plan:
- Reset then single ack (tdata=0x0000_0001_0000_00AA, tdest=3), M_AXIS_tready=1 -> M_AXIS_tvalid rises exactly 1 cycle after push with identical data/dest; occupancy returns 0.
- DEPTH=16, M_AXIS_tready=0, push 20 acks with tdata=i -> exactly 16 accepted, S_AXIS_tready=0 after the 16th, occupancy=16; then drain -> outputs 0..15 in order.
- Both sides valid/ready every cycle for 100 acks -> throughput 1 ack/cycle; occupancy constant at 1; ordering preserved.
- Random tvalid/tready (50%) for 1000 acks with tdest=i mod 256 -> scoreboard matches in order; tdata/tdest stable whenever tvalid=1 and tready=0.
- Assert rst for 1 cycle with occupancy=7 -> M_AXIS_tvalid=0 and occupancy=0 immediately; no stale ack emitted after release.
- With TASK_CREATE_ACK_BUFFER_STATS_EN: push 10 acks with output stalled, then drain -> max_occupancy=10, ack_count=10.

Source files
------------

// File: rtl/task_create_ack_buffer.sv
`default_nettype none
// ============================================================================
// Module   : task_create_ack_buffer
// Purpose  : Elastic in-order FIFO for 64-bit task-create acks and their
//            tdest. Sits after the two-to-one ack switch, decouples the
//            producers from consumer back-pressure and reports occupancy.
//            Storage is a RAM of DEPTH-1 entries feeding one output
//            register, DEPTH entries in total.
// Ports    : clk, rst (async, active-high)
//            S_AXIS_tvalid/tready/tdata/tdest - ack input from the switch
//            M_AXIS_tvalid/tready/tdata/tdest - registered ack output
//            occupancy                        - acks held, incl. output reg
//            ack_count, max_occupancy         - only with the macro below
// Options  : `define TASK_CREATE_ACK_BUFFER_STATS_EN adds the pop counter
//            and the occupancy high-water mark.
// Revision : 1.0 - initial release
// ============================================================================
module task_create_ack_buffer #(
    parameter int  DEST_WIDTH = 8,
    parameter int  DEPTH      = 16,
    localparam int DATA_WIDTH = 64,
    localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  S_AXIS_tvalid,
    output logic                  S_AXIS_tready,
    input  logic [DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic [DEST_WIDTH-1:0] S_AXIS_tdest,
    output logic                  M_AXIS_tvalid,
    input  logic                  M_AXIS_tready,
    output logic [DATA_WIDTH-1:0] M_AXIS_tdata,
    output logic [DEST_WIDTH-1:0] M_AXIS_tdest,
`ifdef TASK_CREATE_ACK_BUFFER_STATS_EN
    output logic [31:0]           ack_count,
    output logic [CNT_WIDTH-1:0]  max_occupancy,
`endif
    output logic [CNT_WIDTH-1:0]  occupancy
);

    localparam int                   RAM_DEPTH   = DEPTH - 1;
    localparam int                   PTR_WIDTH   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int                   ENTRY_WIDTH = DATA_WIDTH + DEST_WIDTH;
    localparam logic [PTR_WIDTH-1:0] PTR_LAST    = PTR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL    = CNT_WIDTH'(DEPTH);

    logic [ENTRY_WIDTH-1:0] mem_q [RAM_DEPTH];

    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   ready_q, ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [ENTRY_WIDTH-1:0] out_entry_q, out_entry_d;

    logic push, pop, ram_empty, out_load, ram_rd, ram_wr;

    always_comb begin
        push      = S_AXIS_tvalid & ready_q;
        pop       = out_valid_q & M_AXIS_tready;
        // The output register is always filled before the RAM, so the RAM
        // holds exactly the acks not sitting in the output register.
        ram_empty = (count_q == CNT_WIDTH'(out_valid_q));
        out_load  = (~out_valid_q | pop) & (~ram_empty | push);
        // RAM contents are older than the incoming ack, so they go first;
        // the incoming ack bypasses the RAM only when the RAM is empty.
        ram_rd    = out_load & ~ram_empty;
        ram_wr    = push & ~(out_load & ram_empty);

        wr_ptr_d = wr_ptr_q;
        if (ram_wr) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        rd_ptr_d = rd_ptr_q;
        if (ram_rd) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        count_d = count_q;
        if (push & ~pop) begin
            count_d = count_q + 1'b1;
        end else if (pop & ~push) begin
            count_d = count_q - 1'b1;
        end
        // Registered from the updated count: no path from M_AXIS_tready.
        ready_d = (count_d < CNT_FULL);

        out_valid_d = out_valid_q;
        out_entry_d = out_entry_q;
        if (out_load) begin
            out_valid_d = 1'b1;
            out_entry_d = ram_rd ? mem_q[rd_ptr_q] : {S_AXIS_tdata, S_AXIS_tdest};
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_entry_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            out_valid_q <= out_valid_d;
            out_entry_q <= out_entry_d;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            mem_q[wr_ptr_q] <= {S_AXIS_tdata, S_AXIS_tdest};
        end
    end

    assign S_AXIS_tready = ready_q;
    assign M_AXIS_tvalid = out_valid_q;
    assign M_AXIS_tdata  = out_entry_q[ENTRY_WIDTH-1:DEST_WIDTH];
    assign M_AXIS_tdest  = out_entry_q[DEST_WIDTH-1:0];
    assign occupancy     = count_q;

`ifdef TASK_CREATE_ACK_BUFFER_STATS_EN
    logic [31:0]          ack_count_q;
    logic [CNT_WIDTH-1:0] max_occ_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_count_q <= '0;
            max_occ_q   <= '0;
        end else begin
            if (pop) begin
                ack_count_q <= ack_count_q + 32'd1;
            end
            if (count_d > max_occ_q) begin
                max_occ_q <= count_d;
            end
        end
    end

    assign ack_count     = ack_count_q;
    assign max_occupancy = max_occ_q;
`endif

endmodule
`default_nettype wire
